// File: rtl/multi_object_collider_pool.sv
// Collider slot pool: valid/ready spawn allocation into the lowest free slot,
// per-slot motion, lifetime and off-screen culling, plus a round-robin scan
// that picks the nearest ground below and the nearest ceiling above the player.
module multi_object_collider_pool #(
   parameter int OBJECT_AMOUNT = 8,
   parameter int COORD_W       = 10,
   parameter int SPEED_W       = 5,
   parameter int GROUND_BUF    = 4
) (
   input  logic                               clk_calculation,
   input  logic                               reset,
   input  logic                               clear_all,
   input  logic                               tick_move,
   input  logic                               tick_centi,
   input  logic                               spawn_valid,
   output logic                               spawn_ready,
   input  logic [COORD_W-1:0]                 spawn_x,
   input  logic [COORD_W-1:0]                 spawn_y,
   input  logic [COORD_W-1:0]                 spawn_w,
   input  logic [COORD_W-1:0]                 spawn_h,
   input  logic [2:0]                         spawn_dir,
   input  logic [SPEED_W-1:0]                 spawn_speed,
   input  logic [7:0]                         spawn_life,
   input  logic [COORD_W-1:0]                 player_x,
   input  logic [COORD_W-1:0]                 player_y,
   input  logic [COORD_W-1:0]                 player_w,
   input  logic [COORD_W-1:0]                 player_h,
   input  logic [COORD_W-1:0]                 disp_x1,
   input  logic [COORD_W-1:0]                 disp_y1,
   input  logic [COORD_W-1:0]                 disp_x2,
   input  logic [COORD_W-1:0]                 disp_y2,
   output logic [OBJECT_AMOUNT-1:0]           active_mask,
   output logic [$clog2(OBJECT_AMOUNT+1)-1:0] active_count,
   output logic                               pool_full,
   output logic                               ground_hit,
   output logic [COORD_W-1:0]                 ground_y,
   output logic [COORD_W-1:0]                 ground_w,
   output logic                               ceil_hit,
   output logic [COORD_W-1:0]                 ceil_y,
   output logic                               scan_done
);

   localparam int CNT_W = $clog2(OBJECT_AMOUNT + 1);
   localparam int IDX_W = (OBJECT_AMOUNT > 1) ? $clog2(OBJECT_AMOUNT) : 1;
   localparam int CW1   = COORD_W + 1;

   typedef enum logic {ST_SCAN, ST_LATCH} scan_state_t;

   // ---------------- slot storage ----------------
   logic [OBJECT_AMOUNT-1:0] active_q, active_d;
   logic [COORD_W-1:0]       x_q    [OBJECT_AMOUNT];
   logic [COORD_W-1:0]       x_d    [OBJECT_AMOUNT];
   logic [COORD_W-1:0]       y_q    [OBJECT_AMOUNT];
   logic [COORD_W-1:0]       y_d    [OBJECT_AMOUNT];
   logic [COORD_W-1:0]       w_q    [OBJECT_AMOUNT];
   logic [COORD_W-1:0]       w_d    [OBJECT_AMOUNT];
   logic [COORD_W-1:0]       h_q    [OBJECT_AMOUNT];
   logic [COORD_W-1:0]       h_d    [OBJECT_AMOUNT];
   logic [2:0]               dir_q  [OBJECT_AMOUNT];
   logic [2:0]               dir_d  [OBJECT_AMOUNT];
   logic [SPEED_W-1:0]       spd_q  [OBJECT_AMOUNT];
   logic [SPEED_W-1:0]       spd_d  [OBJECT_AMOUNT];
   logic [7:0]               life_q [OBJECT_AMOUNT];
   logic [7:0]               life_d [OBJECT_AMOUNT];

   logic             alloc_found;
   logic [IDX_W-1:0] alloc_idx;
   logic             accept;
   logic [CNT_W-1:0] count_c;

   // ---------------- scan state ----------------
   scan_state_t      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             cg_hit_q, cg_hit_d;
   logic [COORD_W-1:0] cg_y_q, cg_y_d, cg_w_q, cg_w_d;
   logic             cc_hit_q, cc_hit_d;
   logic [COORD_W-1:0] cc_y_q, cc_y_d;
   logic             ground_hit_q, ground_hit_d;
   logic [COORD_W-1:0] ground_y_q, ground_y_d, ground_w_q, ground_w_d;
   logic             ceil_hit_q, ceil_hit_d;
   logic [COORD_W-1:0] ceil_y_q, ceil_y_d;
   logic             scan_done_q, scan_done_d;

   assign pool_full    = &active_q;
   assign spawn_ready  = ~pool_full;
   assign accept       = spawn_valid & spawn_ready;
   assign active_mask  = active_q;
   assign active_count = count_c;
   assign ground_hit   = ground_hit_q;
   assign ground_y     = ground_y_q;
   assign ground_w     = ground_w_q;
   assign ceil_hit     = ceil_hit_q;
   assign ceil_y       = ceil_y_q;
   assign scan_done    = scan_done_q;

   // Lowest-index free slot in the registered mask, plus occupancy popcount.
   always_comb begin
      alloc_found = 1'b0;
      alloc_idx   = '0;
      count_c     = '0;
      for (int i = OBJECT_AMOUNT - 1; i >= 0; i--) begin
         if (!active_q[i]) begin
            alloc_found = 1'b1;
            alloc_idx   = IDX_W'(i);
         end
         count_c = count_c + {{(CNT_W-1){1'b0}}, active_q[i]};
      end
   end

   // Per-slot next state: cull, motion, lifetime, then spawn load on the chosen slot.
   always_comb begin
      for (int i = 0; i < OBJECT_AMOUNT; i++) begin
         logic [CW1-1:0] xe, ye, se, sum_x, dif_x, sum_y, dif_y;
         logic [COORD_W-1:0] nx, ny;
         logic cull, move_fail, life_exp;
         xe    = {1'b0, x_q[i]};
         ye    = {1'b0, y_q[i]};
         se    = CW1'(spd_q[i]);
         sum_x = xe + se;
         dif_x = xe - se;
         sum_y = ye + se;
         dif_y = ye - se;
         nx    = x_q[i];
         ny    = y_q[i];
         move_fail = 1'b0;
         cull = ((xe + {1'b0, w_q[i]}) <= {1'b0, disp_x1}) || (x_q[i] >= disp_x2) ||
                ((ye + {1'b0, h_q[i]}) <= {1'b0, disp_y1}) || (y_q[i] >= disp_y2);
         case (dir_q[i])
            3'd1: begin
               move_fail = dif_y[COORD_W] || (dif_y > {1'b0, disp_y2});
               ny        = dif_y[COORD_W-1:0];
            end
            3'd2: begin
               move_fail = sum_y > {1'b0, disp_y2};
               ny        = sum_y[COORD_W-1:0];
            end
            3'd3: begin
               move_fail = dif_x[COORD_W] || (dif_x > {1'b0, disp_x2});
               nx        = dif_x[COORD_W-1:0];
            end
            3'd4: begin
               move_fail = sum_x > {1'b0, disp_x2};
               nx        = sum_x[COORD_W-1:0];
            end
            default: ;
         endcase
         life_exp = tick_centi && (life_q[i] == 8'd1);

         active_d[i] = active_q[i];
         x_d[i]      = x_q[i];
         y_d[i]      = y_q[i];
         w_d[i]      = w_q[i];
         h_d[i]      = h_q[i];
         dir_d[i]    = dir_q[i];
         spd_d[i]    = spd_q[i];
         life_d[i]   = life_q[i];

         if (active_q[i]) begin
            if (cull || (tick_move && move_fail) || life_exp) begin
               active_d[i] = 1'b0;
            end else begin
               if (tick_move) begin
                  x_d[i] = nx;
                  y_d[i] = ny;
               end
               if (tick_centi && (life_q[i] > 8'd1)) begin
                  life_d[i] = life_q[i] - 8'd1;
               end
            end
         end

         // The allocated slot is free in the registered mask, so nothing above touched it.
         if (accept && alloc_found && (alloc_idx == IDX_W'(i))) begin
            active_d[i] = 1'b1;
            x_d[i]      = spawn_x;
            y_d[i]      = spawn_y;
            w_d[i]      = spawn_w;
            h_d[i]      = spawn_h;
            dir_d[i]    = spawn_dir;
            spd_d[i]    = spawn_speed;
            life_d[i]   = spawn_life;
         end
      end
   end

   // Slot register bank; reset and stage-clear both empty the pool.
   always_ff @(posedge clk_calculation) begin
      if (reset || clear_all) begin
         active_q <= '0;
         for (int i = 0; i < OBJECT_AMOUNT; i++) begin
            x_q[i]    <= '0;
            y_q[i]    <= '0;
            w_q[i]    <= '0;
            h_q[i]    <= '0;
            dir_q[i]  <= '0;
            spd_q[i]  <= '0;
            life_q[i] <= '0;
         end
      end else begin
         active_q <= active_d;
         for (int i = 0; i < OBJECT_AMOUNT; i++) begin
            x_q[i]    <= x_d[i];
            y_q[i]    <= y_d[i];
            w_q[i]    <= w_d[i];
            h_q[i]    <= h_d[i];
            dir_q[i]  <= dir_d[i];
            spd_q[i]  <= spd_d[i];
            life_q[i] <= life_d[i];
         end
      end
   end

   // Scan FSM next state: test one slot per SCAN cycle, publish results in LATCH.
   always_comb begin
      logic [CW1-1:0] ox_e, oy_e, ox_end, px_end, feet, feet_buf, bottom;
      logic xov, g_ok, c_ok;
      state_d      = state_q;
      idx_d        = idx_q;
      cg_hit_d     = cg_hit_q;
      cg_y_d       = cg_y_q;
      cg_w_d       = cg_w_q;
      cc_hit_d     = cc_hit_q;
      cc_y_d       = cc_y_q;
      ground_hit_d = ground_hit_q;
      ground_y_d   = ground_y_q;
      ground_w_d   = ground_w_q;
      ceil_hit_d   = ceil_hit_q;
      ceil_y_d     = ceil_y_q;
      scan_done_d  = 1'b0;

      ox_e     = {1'b0, x_q[idx_q]};
      oy_e     = {1'b0, y_q[idx_q]};
      ox_end   = ox_e + {1'b0, w_q[idx_q]};
      px_end   = {1'b0, player_x} + {1'b0, player_w};
      feet     = {1'b0, player_y} + {1'b0, player_h};
      feet_buf = (feet < CW1'(GROUND_BUF)) ? '0 : (feet - CW1'(GROUND_BUF));
      bottom   = oy_e + {1'b0, h_q[idx_q]};
      xov      = (px_end > ox_e) && ({1'b0, player_x} < ox_end);
      g_ok     = active_q[idx_q] && xov && (feet_buf < oy_e);
      c_ok     = active_q[idx_q] && xov && (bottom <= {1'b0, player_y});

      case (state_q)
         ST_SCAN: begin
            if (g_ok && (!cg_hit_q || (y_q[idx_q] < cg_y_q))) begin
               cg_hit_d = 1'b1;
               cg_y_d   = y_q[idx_q];
               cg_w_d   = w_q[idx_q];
            end
            if (c_ok && (!cc_hit_q || (bottom[COORD_W-1:0] > cc_y_q))) begin
               cc_hit_d = 1'b1;
               cc_y_d   = bottom[COORD_W-1:0];
            end
            if (idx_q == IDX_W'(OBJECT_AMOUNT - 1)) begin
               idx_d   = '0;
               state_d = ST_LATCH;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            ground_hit_d = cg_hit_q;
            ground_y_d   = cg_y_q;
            ground_w_d   = cg_w_q;
            ceil_hit_d   = cc_hit_q;
            ceil_y_d     = cc_y_q;
            scan_done_d  = 1'b1;
            cg_hit_d     = 1'b0;
            cg_y_d       = '1;
            cg_w_d       = '0;
            cc_hit_d     = 1'b0;
            cc_y_d       = '0;
            state_d      = ST_SCAN;
         end
      endcase
   end

   // Scan state, candidate and result registers; clear aborts the scan in progress.
   always_ff @(posedge clk_calculation) begin
      if (reset || clear_all) begin
         state_q      <= ST_SCAN;
         idx_q        <= '0;
         cg_hit_q     <= 1'b0;
         cg_y_q       <= '1;
         cg_w_q       <= '0;
         cc_hit_q     <= 1'b0;
         cc_y_q       <= '0;
         ground_hit_q <= 1'b0;
         ground_y_q   <= '1;
         ground_w_q   <= '0;
         ceil_hit_q   <= 1'b0;
         ceil_y_q     <= '0;
         scan_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cg_hit_q     <= cg_hit_d;
         cg_y_q       <= cg_y_d;
         cg_w_q       <= cg_w_d;
         cc_hit_q     <= cc_hit_d;
         cc_y_q       <= cc_y_d;
         ground_hit_q <= ground_hit_d;
         ground_y_q   <= ground_y_d;
         ground_w_q   <= ground_w_d;
         ceil_hit_q   <= ceil_hit_d;
         ceil_y_q     <= ceil_y_d;
         scan_done_q  <= scan_done_d;
      end
   end

endmodule

// File: tb/tb_multi_object_collider_pool.sv
// Directed bench for multi_object_collider_pool with hand-computed expectations.
module tb_multi_object_collider_pool;

   localparam int N  = 8;
   localparam int CW = 10;

   logic          clk_calculation = 1'b0;
   logic          reset = 1'b1;
   logic          clear_all = 1'b0;
   logic          tick_move = 1'b0;
   logic          tick_centi = 1'b0;
   logic          spawn_valid = 1'b0;
   logic          spawn_ready;
   logic [CW-1:0] spawn_x = '0, spawn_y = '0, spawn_w = '0, spawn_h = '0;
   logic [2:0]    spawn_dir = '0;
   logic [4:0]    spawn_speed = '0;
   logic [7:0]    spawn_life = '0;
   logic [CW-1:0] player_x = 10'd100, player_y = 10'd200, player_w = 10'd16, player_h = 10'd16;
   logic [CW-1:0] disp_x1 = 10'd0, disp_y1 = 10'd0, disp_x2 = 10'd639, disp_y2 = 10'd479;
   logic [N-1:0]  active_mask;
   logic [3:0]    active_count;
   logic          pool_full, ground_hit, ceil_hit, scan_done;
   logic [CW-1:0] ground_y, ground_w, ceil_y;

   int n_checks = 0;
   int n_fail   = 0;

   multi_object_collider_pool #(
      .OBJECT_AMOUNT(N), .COORD_W(CW), .SPEED_W(5), .GROUND_BUF(4)
   ) dut (
      .clk_calculation(clk_calculation), .reset(reset), .clear_all(clear_all),
      .tick_move(tick_move), .tick_centi(tick_centi),
      .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
      .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_w(spawn_w), .spawn_h(spawn_h),
      .spawn_dir(spawn_dir), .spawn_speed(spawn_speed), .spawn_life(spawn_life),
      .player_x(player_x), .player_y(player_y), .player_w(player_w), .player_h(player_h),
      .disp_x1(disp_x1), .disp_y1(disp_y1), .disp_x2(disp_x2), .disp_y2(disp_y2),
      .active_mask(active_mask), .active_count(active_count), .pool_full(pool_full),
      .ground_hit(ground_hit), .ground_y(ground_y), .ground_w(ground_w),
      .ceil_hit(ceil_hit), .ceil_y(ceil_y), .scan_done(scan_done)
   );

   always #5 clk_calculation = ~clk_calculation;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk_calculation);
      #1;
   endtask

   task automatic set_spawn(input int x, input int y, input int w, input int h,
                            input int dir, input int spd, input int life);
      spawn_x     = x[CW-1:0];
      spawn_y     = y[CW-1:0];
      spawn_w     = w[CW-1:0];
      spawn_h     = h[CW-1:0];
      spawn_dir   = dir[2:0];
      spawn_speed = spd[4:0];
      spawn_life  = life[7:0];
   endtask

   task automatic spawn(input int x, input int y, input int w, input int h,
                        input int dir, input int spd, input int life);
      set_spawn(x, y, w, h, dir, spd, life);
      spawn_valid = 1'b1;
      step();
      spawn_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear_all = 1'b1;
      step();
      clear_all = 1'b0;
   endtask

   task automatic wait_scan();
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         step();
         if (scan_done) seen = 1'b1;
      end
      check_val("scan_seen", 32'(seen), 32'd1);
   endtask

   // Two pulses guarantee one complete scan after the latest change.
   task automatic full_scan();
      wait_scan();
      wait_scan();
   endtask

   initial begin
      int lat;
      // ---- reset ----
      step(); step(); step();
      reset = 1'b0;
      check_val("rst_mask", 32'(active_mask), 32'd0);
      check_val("rst_count", 32'(active_count), 32'd0);
      check_val("rst_ready", 32'(spawn_ready), 32'd1);
      check_val("rst_ground_y", 32'(ground_y), 32'h3FF);
      check_val("rst_ground_w", 32'(ground_w), 32'd0);
      check_val("rst_ceil_y", 32'(ceil_y), 32'd0);
      check_val("rst_scan_done", 32'(scan_done), 32'd0);
      lat = 0;
      for (int k = 1; k <= 30 && lat == 0; k++) begin
         step();
         if (scan_done) lat = k;
      end
      check_val("first_scan_latency", 32'(lat), 32'd9);

      // ---- fill the pool with valid held ----
      spawn_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
         set_spawn(20 + 10 * i, 10, 5, 5, 0, 0, (i == 3) ? 1 : 0);
         step();
         check_val($sformatf("fill_mask_%0d", i), 32'(active_mask), (32'd1 << (i + 1)) - 32'd1);
      end
      check_val("full_pool_full", 32'(pool_full), 32'd1);
      check_val("full_ready", 32'(spawn_ready), 32'd0);
      set_spawn(300, 10, 5, 5, 0, 0, 0);
      step();
      check_val("stall_mask", 32'(active_mask), 32'hFF);
      check_val("stall_count", 32'(active_count), 32'd8);
      spawn_valid = 1'b0;
      tick_centi = 1'b1;
      step();
      tick_centi = 1'b0;
      check_val("life_free_mask", 32'(active_mask), 32'hF7);
      check_val("life_free_count", 32'(active_count), 32'd7);
      check_val("life_free_ready", 32'(spawn_ready), 32'd1);
      spawn(300, 10, 5, 5, 0, 0, 0);
      check_val("refill_slot3", 32'(active_mask), 32'hFF);
      do_clear();
      check_val("clear_mask", 32'(active_mask), 32'd0);

      // ---- ground select ----
      spawn(90, 230, 40, 8, 0, 0, 0);
      spawn(95, 220, 40, 8, 0, 0, 0);
      full_scan();
      check_val("gnd_hit", 32'(ground_hit), 32'd1);
      check_val("gnd_y", 32'(ground_y), 32'd220);
      check_val("gnd_w", 32'(ground_w), 32'd40);
      check_val("gnd_no_ceil", 32'(ceil_hit), 32'd0);
      do_clear();
      spawn(100, 211, 40, 8, 0, 0, 0);
      full_scan();
      check_val("gnd_reject_211", 32'(ground_hit), 32'd0);
      spawn(100, 213, 30, 8, 0, 0, 0);
      full_scan();
      check_val("gnd_accept_213_hit", 32'(ground_hit), 32'd1);
      check_val("gnd_accept_213_y", 32'(ground_y), 32'd213);
      check_val("gnd_accept_213_w", 32'(ground_w), 32'd30);
      do_clear();

      // ---- ceiling ----
      spawn(100, 150, 20, 50, 0, 0, 0);
      full_scan();
      check_val("ceil_hit", 32'(ceil_hit), 32'd1);
      check_val("ceil_y", 32'(ceil_y), 32'd200);
      check_val("ceil_no_gnd", 32'(ground_hit), 32'd0);
      do_clear();
      spawn(100, 151, 20, 50, 0, 0, 0);
      full_scan();
      check_val("ceil_bottom_201", 32'(ceil_hit), 32'd0);
      do_clear();

      // ---- motion and cull ----
      spawn(5, 50, 8, 8, 3, 6, 0);
      check_val("left_spawned", 32'(active_mask), 32'd1);
      tick_move = 1'b1;
      step();
      tick_move = 1'b0;
      check_val("left_borrow_freed", 32'(active_mask), 32'd0);
      spawn(630, 50, 8, 8, 4, 10, 0);
      check_val("right_spawned", 32'(active_mask), 32'd1);
      tick_move = 1'b1;
      step();
      tick_move = 1'b0;
      check_val("right_edge_freed", 32'(active_mask), 32'd0);
      spawn(100, 230, 40, 8, 1, 5, 0);
      tick_move = 1'b1;
      step();
      tick_move = 1'b0;
      full_scan();
      check_val("up_moved_y", 32'(ground_y), 32'd225);
      do_clear();
      set_spawn(100, 230, 40, 8, 1, 5, 0);
      spawn_valid = 1'b1;
      tick_move   = 1'b1;
      step();
      spawn_valid = 1'b0;
      tick_move   = 1'b0;
      full_scan();
      check_val("spawn_with_tick_unmoved", 32'(ground_y), 32'd230);
      do_clear();

      // ---- clear_all mid-scan ----
      for (int i = 0; i < 5; i++) spawn(90 + 2 * i, 220 + 2 * i, 40, 8, 0, 0, 0);
      check_val("five_count", 32'(active_count), 32'd5);
      full_scan();
      check_val("five_gnd_y", 32'(ground_y), 32'd220);
      step(); step(); step();
      do_clear();
      check_val("midscan_clear_mask", 32'(active_mask), 32'd0);
      check_val("midscan_clear_gnd_y", 32'(ground_y), 32'h3FF);
      wait_scan();
      check_val("post_clear_gnd_hit", 32'(ground_hit), 32'd0);
      check_val("post_clear_ceil_hit", 32'(ceil_hit), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
